er_exec_monitor: RTL and testbench
==================================

# er_exec_monitor

Executable-region monitor that consumes the ER_min/ER_max bounds from the VERSA metadata peripheral and watches the core's instruction fetches, interrupts and data writes. It asserts `exec` only after the region has been entered at ER_min, run without interruption or tampering, and left at ER_max, and it holds `exec` until something invalidates the run. It sits between the metadata registers and the attestation logic, which samples `exec`.

## Interface
- `CNT_W`, 16: width of the run-cycle counter.
- `mclk` in 1: main system clock; all state updates on its rising edge.
- `puc_rst` in 1: reset, synchronous, active-high.
- `pc` in 16: address of the instruction being fetched.
- `pc_vld` in 1: `pc` is a new fetch this cycle.
- `irq` in 1: interrupt taken this cycle.
- `data_en` in 1: data-bus access this cycle.
- `data_wr` in 1: the data access is a write.
- `data_addr` in 16: data-bus address.
- `ER_min` in 16: region entry address, from the metadata block.
- `ER_max` in 16: region exit address, from the metadata block.
- `exec` out 1: region completed legitimately and is still untouched.
- `violation` out 1: one-cycle pulse when a run is aborted.
- `er_busy` out 1: high while in RUN.
- `run_cycles` out CNT_W: mclk cycles spent in the last or current run.

## Operation
- Region is valid iff `ER_min < ER_max` (unsigned). When it is invalid, no run starts.
- In-region means `ER_min <= addr <= ER_max`, inclusive. `ER_min`/`ER_max` are snapshotted into `min_q`/`max_q` on RUN entry. `cfg_chg = (ER_min != min_q) | (ER_max != max_q)`.
- `wr_hit` = `data_en & data_wr` with `data_addr` in-region, judged against the live bounds.
- States:
  - IDLE (encoding 0): `exec`=0.
  - RUN (1): `er_busy`=1.
  - DONE (2): `exec`=1.
- IDLE → RUN when `pc_vld & pc==ER_min & valid & ~irq`. Snapshot taken; `run_cycles` loaded to 1.
- RUN aborts to IDLE with `violation` when any of the following holds:
  - `cfg_chg`, or
  - `irq`, or
  - `wr_hit`, or
  - `pc_vld` with `pc` outside [`min_q`, `max_q`].
- Abort has priority over completion.
- RUN → DONE when `pc_vld & pc==max_q` and there is no abort cause.
- Otherwise RUN stays in RUN, and `run_cycles` increments each cycle, saturating at all-ones.
- DONE → IDLE when `cfg_chg` or `wr_hit`. No `violation` pulse in this case.
- DONE → RUN when `pc_vld & pc==ER_min & valid & ~irq` (re-execution). This takes priority over staying in DONE, but `cfg_chg`/`wr_hit` take priority over re-entry. `exec` drops on entry.
- `run_cycles` holds its value in IDLE and DONE. It is cleared only by reset or RUN entry.
- An `irq` or out-of-region `pc` while in DONE or IDLE has no effect.
- Reset: state IDLE, `exec`=0, `violation`=0, `er_busy`=0, `run_cycles`=0, `min_q`=0, `max_q`=0.

## Timing
- All outputs are registered and reflect the state after the edge at which the condition was sampled. Latency from triggering input to output is 1 cycle.
- `violation` is high for exactly the one cycle after the abort edge.
- `exec` rises 1 cycle after the `pc_vld` carrying `pc==ER_max`. It falls 1 cycle after an invalidating `wr_hit`, `cfg_chg` or re-entry.
- `run_cycles` counts the entry cycle as 1 and includes the ER_max fetch cycle.
- `puc_rst` asserted mid-run forces IDLE at the next edge, with no `violation` pulse. Reset dominates all other inputs.
- A write to ER_min/ER_max through the metadata block appears as `cfg_chg` one cycle after that block's register updates.

## Test plan
- Nominal run: ER_min=E07A, ER_max=F000; fetch E07A, E07C, then F000 on the 3rd `pc_vld` (cycles consecutive) → `exec`=1 the cycle after F000, `run_cycles`=3, `violation` never pulses.
- IRQ abort: start a run at E07A, assert `irq` on the same cycle as the F000 fetch → state IDLE, one-cycle `violation`, `exec` stays 0.
- Tamper after completion: reach DONE, then `data_en=data_wr=1` with `data_addr`=E100 → `exec` falls next cycle, no `violation`. Repeating with `data_addr`=F002 leaves `exec` at 1.
- Config change mid-run: during RUN, change ER_max to F100 → abort with `violation`. In DONE, the same change clears `exec` without `violation`.
- Escape and invalid region: fetch `pc`=C000 mid-run → `violation`. With ER_min=F000 and ER_max=E07A, fetching F000 never leaves IDLE.
- Counter saturation and reset: with CNT_W=4, stay in RUN for 20 cycles → `run_cycles`=F. Assert `puc_rst` → all outputs 0 at the next edge.

Source files
------------

// File: rtl/er_exec_monitor.sv
// Executable-region monitor: raises exec once ER_min..ER_max has run start to finish
// without interrupts, escapes, region writes or bound changes, and holds it until invalidated.
module er_exec_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic [15:0]      pc,
    input  logic             pc_vld,
    input  logic             irq,
    input  logic             data_en,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    output logic             exec,
    output logic             violation,
    output logic             er_busy,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      min_q, min_d;
    logic [15:0]      max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol_q, viol_d;

    logic             region_vld;
    logic             entry;
    logic             wr_hit;
    logic             cfg_chg;
    logic             pc_out;
    logic             abort;
    logic [CNT_W-1:0] cnt_inc;

    assign region_vld = ER_min < ER_max;
    assign entry      = pc_vld & (pc == ER_min) & region_vld & ~irq;
    // Tamper writes are judged against the live bounds, escapes against the snapshot.
    assign wr_hit     = data_en & data_wr & (data_addr >= ER_min) & (data_addr <= ER_max);
    assign cfg_chg    = (ER_min != min_q) | (ER_max != max_q);
    assign pc_out     = pc_vld & ((pc < min_q) | (pc > max_q));
    assign abort      = cfg_chg | irq | wr_hit | pc_out;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        viol_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (entry) begin
                    state_d = StRun;
                    min_d   = ER_min;
                    max_d   = ER_max;
                    cnt_d   = CNT_W'(1);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    viol_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (pc_vld && (pc == max_q)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (cfg_chg || wr_hit) begin
                    state_d = StIdle;
                end else if (entry) begin
                    state_d = StRun;
                    min_d   = ER_min;
                    max_d   = ER_max;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= StIdle;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            viol_q  <= viol_d;
        end
    end

    assign exec       = (state_q == StDone);
    assign er_busy    = (state_q == StRun);
    assign violation  = viol_q;
    assign run_cycles = cnt_q;

endmodule

// File: tb/tb_er_exec_monitor.sv
// Bench for er_exec_monitor: directed scenarios plus randomized traffic against a
// rule-level reference model of the region-execution protocol.
module tb_er_exec_monitor;

    localparam int unsigned CNT_W = 4;

    logic             mclk = 1'b0;
    logic             puc_rst;
    logic [15:0]      pc;
    logic             pc_vld;
    logic             irq;
    logic             data_en;
    logic             data_wr;
    logic [15:0]      data_addr;
    logic [15:0]      ER_min;
    logic [15:0]      ER_max;
    logic             exec;
    logic             violation;
    logic             er_busy;
    logic [CNT_W-1:0] run_cycles;

    int checks   = 0;
    int failures = 0;

    er_exec_monitor #(.CNT_W(CNT_W)) dut (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .pc         (pc),
        .pc_vld     (pc_vld),
        .irq        (irq),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .ER_min     (ER_min),
        .ER_max     (ER_max),
        .exec       (exec),
        .violation  (violation),
        .er_busy    (er_busy),
        .run_cycles (run_cycles)
    );

    always #5 mclk = ~mclk;

    // Reference model: phase of the protocol, snapshot bounds, cycles spent running.
    bit              m_running;
    bit              m_completed;
    int unsigned     m_lo;
    int unsigned     m_hi;
    int unsigned     m_cycles;
    bit              m_viol;

    function automatic int unsigned sat(input int unsigned v);
        return (v > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : v;
    endfunction

    task automatic model_update();
        int unsigned a, lo, hi;
        bit starts, tamper, moved, escaped;
        a       = int'(pc);
        lo      = int'(ER_min);
        hi      = int'(ER_max);
        starts  = pc_vld && a == lo && lo < hi && !irq;
        tamper  = data_en && data_wr && int'(data_addr) >= lo && int'(data_addr) <= hi;
        moved   = lo != m_lo || hi != m_hi;
        escaped = pc_vld && (a < m_lo || a > m_hi);
        m_viol  = 1'b0;
        if (puc_rst) begin
            m_running = 0; m_completed = 0; m_lo = 0; m_hi = 0; m_cycles = 0;
        end else if (m_running) begin
            if (moved || irq || tamper || escaped) begin
                m_running = 0;
                m_viol    = 1'b1;
            end else begin
                m_cycles = sat(m_cycles + 1);
                if (pc_vld && a == m_hi) begin
                    m_running   = 0;
                    m_completed = 1;
                end
            end
        end else if (m_completed && (moved || tamper)) begin
            m_completed = 0;
        end else if (starts) begin
            m_running   = 1;
            m_completed = 0;
            m_lo        = lo;
            m_hi        = hi;
            m_cycles    = 1;
        end
    endtask

    function automatic logic [CNT_W+2:0] model_vec();
        return {m_completed, m_viol, m_running, CNT_W'(m_cycles)};
    endfunction

    task automatic step();
        model_update();
        @(posedge mclk);
        #1;
    endtask

    task automatic quiet();
        pc_vld = 0; irq = 0; data_en = 0; data_wr = 0; pc = 16'h0000; data_addr = 16'h0000;
    endtask

    task automatic do_reset();
        quiet();
        puc_rst = 1;
        step();
        puc_rst = 0;
    endtask

    task automatic fetch(input logic [15:0] a);
        pc = a;
        pc_vld = 1;
        step();
        pc_vld = 0;
    endtask

    task automatic test_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        do_reset();
        checks++;
        if ({exec, violation, er_busy, run_cycles} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {exec, violation, er_busy, run_cycles});
        end
    endtask

    task automatic test_nominal();
        int viol_seen = 0;
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A); viol_seen += violation;
        checks++;
        if (er_busy !== 1'b1) begin
            failures++; $display("FAIL nominal_busy got=%b want=1", er_busy);
        end
        fetch(16'hE07C); viol_seen += violation;
        fetch(16'hF000); viol_seen += violation;
        checks++;
        if (exec !== 1'b1 || run_cycles !== CNT_W'(3)) begin
            failures++;
            $display("FAIL nominal_done got exec=%b cycles=%0d want exec=1 cycles=3", exec, run_cycles);
        end
        step(); viol_seen += violation;
        checks++;
        if (viol_seen != 0 || exec !== 1'b1) begin
            failures++;
            $display("FAIL nominal_hold got viol_cnt=%0d exec=%b want 0 and 1", viol_seen, exec);
        end
    endtask

    task automatic test_irq_abort();
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A);
        fetch(16'hE07C);
        irq = 1;
        fetch(16'hF000);
        irq = 0;
        checks++;
        if ({violation, exec, er_busy} !== 3'b100) begin
            failures++;
            $display("FAIL irq_abort got v/e/b=%b want 100", {violation, exec, er_busy});
        end
        step();
        checks++;
        if ({violation, exec, er_busy} !== 3'b000) begin
            failures++;
            $display("FAIL irq_pulse_width got v/e/b=%b want 000", {violation, exec, er_busy});
        end
    endtask

    task automatic test_tamper_done();
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A);
        fetch(16'hF000);
        data_en = 1; data_wr = 1; data_addr = 16'hF002;
        step();
        checks++;
        if (exec !== 1'b1) begin
            failures++; $display("FAIL tamper_outside got exec=%b want 1", exec);
        end
        data_addr = 16'hE100;
        step();
        data_en = 0; data_wr = 0;
        checks++;
        if ({exec, violation} !== 2'b00) begin
            failures++; $display("FAIL tamper_inside got exec/viol=%b want 00", {exec, violation});
        end
    endtask

    task automatic test_cfg_change();
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A);
        ER_max = 16'hF100;
        step();
        checks++;
        if ({violation, er_busy} !== 2'b10) begin
            failures++; $display("FAIL cfg_run got viol/busy=%b want 10", {violation, er_busy});
        end
        ER_max = 16'hF000;
        fetch(16'hE07A);
        fetch(16'hF000);
        ER_max = 16'hF100;
        step();
        checks++;
        if ({exec, violation} !== 2'b00) begin
            failures++; $display("FAIL cfg_done got exec/viol=%b want 00", {exec, violation});
        end
    endtask

    task automatic test_escape_invalid();
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A);
        fetch(16'hC000);
        checks++;
        if ({violation, er_busy} !== 2'b10) begin
            failures++; $display("FAIL escape got viol/busy=%b want 10", {violation, er_busy});
        end
        ER_min = 16'hF000; ER_max = 16'hE07A;
        fetch(16'hF000);
        fetch(16'hF000);
        checks++;
        if ({er_busy, exec, violation} !== 3'b000) begin
            failures++; $display("FAIL invalid_region got b/e/v=%b want 000", {er_busy, exec, violation});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ER_min = 16'hE07A; ER_max = 16'hF000;
        fetch(16'hE07A);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (run_cycles !== 4'hF || er_busy !== 1'b1) begin
            failures++;
            $display("FAIL saturation got cycles=%h busy=%b want F 1", run_cycles, er_busy);
        end
        puc_rst = 1;
        step();
        puc_rst = 0;
        checks++;
        if ({exec, violation, er_busy, run_cycles} !== '0) begin
            failures++;
            $display("FAIL reset_midrun got=%h want=0", {exec, violation, er_busy, run_cycles});
        end
    endtask

    task automatic test_random();
        logic [15:0] mins [3];
        logic [15:0] maxs [3];
        int unsigned r;
        mins = '{16'hE07A, 16'h1000, 16'hF000};
        maxs = '{16'hF000, 16'h1010, 16'hE07A};
        do_reset();
        ER_min = mins[0]; ER_max = maxs[0];
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) ER_min = mins[$urandom_range(0, 2)];
            if ($urandom_range(0, 99) == 0) ER_max = maxs[$urandom_range(0, 2)];
            puc_rst = ($urandom_range(0, 299) == 0);
            pc_vld  = ($urandom_range(0, 3) != 0);
            irq     = ($urandom_range(0, 39) == 0);
            data_en = ($urandom_range(0, 7) == 0);
            data_wr = ($urandom_range(0, 1) == 0);
            r = $urandom_range(0, 9);
            if (r < 3)      pc = ER_min;
            else if (r < 5) pc = ER_max;
            else if (r < 9) pc = ER_min + 16'($urandom_range(0, 32));
            else            pc = 16'($urandom);
            data_addr = ($urandom_range(0, 1) == 0) ? ER_min + 16'($urandom_range(0, 64))
                                                    : 16'($urandom);
            step();
            checks++;
            if ({exec, violation, er_busy, run_cycles} !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d got e/v/b/c=%b want %b", i,
                         {exec, violation, er_busy, run_cycles}, model_vec());
            end
        end
        puc_rst = 0;
        quiet();
    endtask

    initial begin
        quiet();
        puc_rst = 1;
        ER_min = 16'h0000; ER_max = 16'h0000;
        test_reset();
        test_nominal();
        test_irq_abort();
        test_tamper_done();
        test_cfg_change();
        test_escape_invalid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
